// File: rtl/keypad_multitap_encoder.sv
// Keypad matrix scanner with frame-based debounce and multi-tap letter entry.
// Produces one-cycle commit pulses for the hangman game logic.
module keypad_multitap_encoder #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE        = 3,
    parameter int TAP_TIMEOUT     = 2000,
    parameter int LETTERS_PER_KEY = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ROWS-1:0]              row_in,
    output logic [COLS-1:0]              col_out,
    output logic                         key_press,
    output logic [$clog2(ROWS*COLS)-1:0] key_index,
    output logic [7:0]                   cur_letter,
    output logic                         cur_valid,
    output logic                         letter_ready,
    output logic [7:0]                   letter_out,
    output logic                         word_submit,
    output logic                         entry_error
);
    localparam int KW          = $clog2(ROWS * COLS);
    localparam int CW          = $clog2(COLS);
    localparam int DW          = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int BW          = $clog2(DEBOUNCE + 1);
    localparam int TW          = $clog2(TAP_TIMEOUT + 1);
    localparam int LW          = (LETTERS_PER_KEY > 1) ? $clog2(LETTERS_PER_KEY) : 1;
    localparam int LETTER_KEYS = (ROWS - 1) * COLS;
    localparam int ALPHABET    = 26;

    // Frame result encoding doubles as a saturating closure count.
    localparam logic [1:0] RES_NONE  = 2'd0;
    localparam logic [1:0] RES_KEY   = 2'd1;
    localparam logic [1:0] RES_MULTI = 2'd2;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PRESSED = 1'b1} state_t;

    // Number of letters owned by letter key k (0 for keys past 'Z').
    function automatic int letters_on_key(input int k);
        int base;
        base = k * LETTERS_PER_KEY;
        if (base >= ALPHABET) begin
            return 32'sd0;
        end else if (ALPHABET - base < LETTERS_PER_KEY) begin
            return ALPHABET - base;
        end else begin
            return LETTERS_PER_KEY;
        end
    endfunction

    logic [ROWS-1:0] row_s1_q, row_s2_q;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [CW-1:0]   col_idx_q, col_idx_d;
    logic [COLS-1:0] col_out_q, col_out_d;
    logic            last_s, last_p1_q, last_p2_q;
    logic [CW-1:0]   col_p1_q, col_p2_q;
    logic [1:0]      col_hits_s;
    logic [KW-1:0]   col_key_s;
    logic [2:0]      sum_s;
    logic [1:0]      frame_res_s;
    logic [KW-1:0]   frame_key_s;
    logic            frame_end_s;
    logic [1:0]      acc_hits_q, acc_hits_d;
    logic [KW-1:0]   acc_key_q, acc_key_d;
    logic [1:0]      prev_res_q, prev_res_d;
    logic [KW-1:0]   prev_key_q, prev_key_d;
    logic [BW-1:0]   stab_cnt_q, stab_cnt_d, stab_next_s;
    logic            same_s, stable_s;
    state_t          state_q, state_d;
    logic            key_press_q, key_press_d;
    logic [KW-1:0]   key_index_q, key_index_d;
    logic [7:0]      cur_letter_q, cur_letter_d;
    logic            cur_valid_q, cur_valid_d;
    logic [LW-1:0]   tap_idx_q, tap_idx_d;
    logic [KW-1:0]   last_lkey_q, last_lkey_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      letter_out_q, letter_out_d;
    logic            letter_ready_q, letter_ready_d;
    logic            word_submit_q, word_submit_d;
    logic            entry_error_q, entry_error_d;
    int              nk_s;
    logic            repeat_s;
    logic [KW-1:0]   ctrl_col_s;

    // Column drive rotation: dwell counter, column index and one-hot drive.
    always_comb begin
        last_s    = (dwell_q == DW'(SCAN_CYCLES - 1));
        dwell_d   = dwell_q;
        col_idx_d = col_idx_q;
        col_out_d = col_out_q;
        if (last_s) begin
            dwell_d   = '0;
            col_out_d = {col_out_q[COLS-2:0], col_out_q[COLS-1]};
            if (col_idx_q == CW'(COLS - 1)) begin
                col_idx_d = '0;
            end else begin
                col_idx_d = col_idx_q + CW'(1);
            end
        end else begin
            dwell_d = dwell_q + DW'(1);
        end
    end

    // Frame accumulation; sample strobe and column are delayed to line up with the synchroniser.
    always_comb begin
        col_hits_s = 2'd0;
        col_key_s  = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_s2_q[r] && (col_hits_s == 2'd0)) begin
                col_hits_s = 2'd1;
                col_key_s  = KW'(r * COLS + int'(col_p2_q));
            end else if (row_s2_q[r]) begin
                col_hits_s = RES_MULTI;
            end else begin
                col_hits_s = col_hits_s;
            end
        end
        sum_s       = {1'b0, acc_hits_q} + {1'b0, col_hits_s};
        frame_res_s = (sum_s >= 3'd2) ? RES_MULTI : sum_s[1:0];
        frame_key_s = (acc_hits_q == RES_NONE) ? col_key_s : acc_key_q;
        frame_end_s = last_p2_q && (col_p2_q == CW'(COLS - 1));
        acc_hits_d  = acc_hits_q;
        acc_key_d   = acc_key_q;
        if (frame_end_s) begin
            acc_hits_d = RES_NONE;
            acc_key_d  = '0;
        end else if (last_p2_q) begin
            acc_hits_d = frame_res_s;
            acc_key_d  = frame_key_s;
        end else begin
            acc_hits_d = acc_hits_q;
        end
    end

    // Debounce FSM next state: count identical frames, press/release after DEBOUNCE of them.
    always_comb begin
        same_s      = (frame_res_s == prev_res_q) &&
                      ((frame_res_s != RES_KEY) || (frame_key_s == prev_key_q));
        stab_next_s = same_s ? ((stab_cnt_q == BW'(DEBOUNCE)) ? stab_cnt_q : stab_cnt_q + BW'(1))
                             : BW'(1);
        stable_s    = (stab_next_s == BW'(DEBOUNCE));
        state_d     = state_q;
        prev_res_d  = prev_res_q;
        prev_key_d  = prev_key_q;
        stab_cnt_d  = stab_cnt_q;
        key_press_d = 1'b0;
        key_index_d = key_index_q;
        if (frame_end_s) begin
            prev_res_d = frame_res_s;
            prev_key_d = frame_key_s;
            stab_cnt_d = stab_next_s;
            case (state_q)
                ST_IDLE: begin
                    if ((frame_res_s == RES_KEY) && stable_s) begin
                        state_d     = ST_PRESSED;
                        key_press_d = 1'b1;
                        key_index_d = frame_key_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if ((frame_res_s == RES_NONE) && stable_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Multi-tap letter entry and control-key actions, one cycle after key_press.
    always_comb begin
        nk_s           = letters_on_key(int'(key_index_q));
        ctrl_col_s     = key_index_q - KW'(LETTER_KEYS);
        repeat_s       = cur_valid_q && (last_lkey_q == key_index_q) &&
                         (tmo_q < TW'(TAP_TIMEOUT));
        cur_letter_d   = cur_letter_q;
        cur_valid_d    = cur_valid_q;
        tap_idx_d      = tap_idx_q;
        last_lkey_d    = last_lkey_q;
        tmo_d          = (tmo_q == TW'(TAP_TIMEOUT)) ? tmo_q : tmo_q + TW'(1);
        letter_out_d   = letter_out_q;
        letter_ready_d = 1'b0;
        word_submit_d  = 1'b0;
        entry_error_d  = 1'b0;
        if (key_press_q) begin
            tmo_d = '0;
            if (int'(key_index_q) < LETTER_KEYS) begin
                if (nk_s > 0) begin
                    if (repeat_s && (int'(tap_idx_q) + 32'sd1 < nk_s)) begin
                        tap_idx_d = tap_idx_q + LW'(1);
                    end else if (repeat_s) begin
                        tap_idx_d = '0;
                    end else begin
                        tap_idx_d   = '0;
                        cur_valid_d = 1'b1;
                    end
                    last_lkey_d  = key_index_q;
                    cur_letter_d = 8'h41 + 8'(int'(key_index_q) * LETTERS_PER_KEY) + 8'(tap_idx_d);
                end else begin
                    cur_letter_d = cur_letter_q;
                end
            end else begin
                case (ctrl_col_s)
                    KW'(0): begin
                        if (cur_valid_q) begin
                            letter_out_d   = cur_letter_q;
                            letter_ready_d = 1'b1;
                            cur_valid_d    = 1'b0;
                        end else begin
                            entry_error_d = 1'b1;
                        end
                    end
                    KW'(1):  cur_valid_d   = 1'b0;
                    KW'(2):  word_submit_d = 1'b1;
                    default: cur_valid_d   = cur_valid_q;
                endcase
            end
        end else begin
            cur_valid_d = cur_valid_q;
        end
    end

    // State register for synchroniser, scanner, debounce and entry logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q       <= '0;
            row_s2_q       <= '0;
            dwell_q        <= '0;
            col_idx_q      <= '0;
            col_out_q      <= COLS'(1);
            last_p1_q      <= 1'b0;
            last_p2_q      <= 1'b0;
            col_p1_q       <= '0;
            col_p2_q       <= '0;
            acc_hits_q     <= RES_NONE;
            acc_key_q      <= '0;
            prev_res_q     <= RES_NONE;
            prev_key_q     <= '0;
            stab_cnt_q     <= '0;
            state_q        <= ST_IDLE;
            key_press_q    <= 1'b0;
            key_index_q    <= '0;
            cur_letter_q   <= 8'h00;
            cur_valid_q    <= 1'b0;
            tap_idx_q      <= '0;
            last_lkey_q    <= '0;
            tmo_q          <= '0;
            letter_out_q   <= 8'h00;
            letter_ready_q <= 1'b0;
            word_submit_q  <= 1'b0;
            entry_error_q  <= 1'b0;
        end else begin
            row_s1_q       <= row_in;
            row_s2_q       <= row_s1_q;
            dwell_q        <= dwell_d;
            col_idx_q      <= col_idx_d;
            col_out_q      <= col_out_d;
            last_p1_q      <= last_s;
            last_p2_q      <= last_p1_q;
            col_p1_q       <= col_idx_q;
            col_p2_q       <= col_p1_q;
            acc_hits_q     <= acc_hits_d;
            acc_key_q      <= acc_key_d;
            prev_res_q     <= prev_res_d;
            prev_key_q     <= prev_key_d;
            stab_cnt_q     <= stab_cnt_d;
            state_q        <= state_d;
            key_press_q    <= key_press_d;
            key_index_q    <= key_index_d;
            cur_letter_q   <= cur_letter_d;
            cur_valid_q    <= cur_valid_d;
            tap_idx_q      <= tap_idx_d;
            last_lkey_q    <= last_lkey_d;
            tmo_q          <= tmo_d;
            letter_out_q   <= letter_out_d;
            letter_ready_q <= letter_ready_d;
            word_submit_q  <= word_submit_d;
            entry_error_q  <= entry_error_d;
        end
    end

    assign col_out      = col_out_q;
    assign key_press    = key_press_q;
    assign key_index    = key_index_q;
    assign cur_letter   = cur_letter_q;
    assign cur_valid    = cur_valid_q;
    assign letter_ready = letter_ready_q;
    assign letter_out   = letter_out_q;
    assign word_submit  = word_submit_q;
    assign entry_error  = entry_error_q;

endmodule

// File: tb/tb_keypad_multitap_encoder.sv
// Scoreboard bench for keypad_multitap_encoder: stimulus pushes expected
// press outcomes, a monitor pops and compares whenever key_press fires.
module tb_keypad_multitap_encoder;
    localparam int K_NONE   = 0;
    localparam int K_LETTER = 1;
    localparam int K_WORD   = 2;
    localparam int K_ERR    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_press;
    logic [3:0]  key_index;
    logic [7:0]  cur_letter;
    logic        cur_valid;
    logic        letter_ready;
    logic [7:0]  letter_out;
    logic        word_submit;
    logic        entry_error;
    logic [15:0] held = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         key;
        logic [7:0] letter;
        logic       valid;
        int         kind;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_e;
    bit   chk_next = 1'b0;

    always #5 clk = ~clk;

    keypad_multitap_encoder #(
        .ROWS(4), .COLS(4), .SCAN_CYCLES(2), .DEBOUNCE(3),
        .TAP_TIMEOUT(100), .LETTERS_PER_KEY(3)
    ) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .key_press(key_press), .key_index(key_index),
        .cur_letter(cur_letter), .cur_valid(cur_valid),
        .letter_ready(letter_ready), .letter_out(letter_out),
        .word_submit(word_submit), .entry_error(entry_error)
    );

    // Physical matrix: a held key connects its column drive to its row sense.
    always_comb begin
        row_in = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (held[r*4+c] && col_out[c]) row_in[r] = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_press(input int key, input logic [7:0] letter, input logic valid, input int kind);
        exp_t e;
        e.key = key; e.letter = letter; e.valid = valid; e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic tap(input int k, input int hold, input int gap);
        held[k] = 1'b1;
        repeat (hold) @(negedge clk);
        held[k] = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col_out"},      {28'b0, col_out},      32'h1);
        check({tag, "_key_press"},    {31'b0, key_press},    32'h0);
        check({tag, "_key_index"},    {28'b0, key_index},    32'h0);
        check({tag, "_cur_letter"},   {24'b0, cur_letter},   32'h0);
        check({tag, "_cur_valid"},    {31'b0, cur_valid},    32'h0);
        check({tag, "_letter_ready"}, {31'b0, letter_ready}, 32'h0);
        check({tag, "_letter_out"},   {24'b0, letter_out},   32'h0);
        check({tag, "_word_submit"},  {31'b0, word_submit},  32'h0);
        check({tag, "_entry_error"},  {31'b0, entry_error},  32'h0);
    endtask

    // Monitor: pop on each key_press, check the follow-up cycle, flag stray pulses.
    always @(negedge clk) begin
        if (chk_next) begin
            check("cur_letter",   {24'b0, cur_letter},   {24'b0, cur_e.letter});
            check("cur_valid",    {31'b0, cur_valid},    {31'b0, cur_e.valid});
            check("letter_ready", {31'b0, letter_ready}, {31'b0, cur_e.kind == K_LETTER});
            check("word_submit",  {31'b0, word_submit},  {31'b0, cur_e.kind == K_WORD});
            check("entry_error",  {31'b0, entry_error},  {31'b0, cur_e.kind == K_ERR});
            if (cur_e.kind == K_LETTER) check("letter_out", {24'b0, letter_out}, {24'b0, cur_e.letter});
            chk_next = 1'b0;
        end else if (letter_ready || word_submit || entry_error) begin
            check("stray_pulse", {29'b0, letter_ready, word_submit, entry_error}, 32'h0);
        end
        if (key_press) begin
            if (exp_q.size() == 0) begin
                check("unexpected_press", {31'b0, key_press}, 32'h0);
            end else begin
                cur_e = exp_q.pop_front();
                check("key_index", {28'b0, key_index}, cur_e.key);
                chk_next = 1'b1;
            end
        end
    end

    initial begin
        rst  = 1'b1;
        held = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Row0 held while col0 is scanned for 40 cycles -> single press of key 0, 'A'.
        expect_press(0, 8'h41, 1'b1, K_NONE);
        tap(0, 40, 32);

        // Clear, then a double tap on key 0 (taps ~30 cycles apart) and submit -> 'B'.
        expect_press(13, 8'h41, 1'b0, K_NONE);
        tap(13, 32, 32);
        expect_press(0, 8'h41, 1'b1, K_NONE);
        tap(0, 32, 32);
        expect_press(0, 8'h42, 1'b1, K_NONE);
        tap(0, 32, 32);
        expect_press(12, 8'h42, 1'b0, K_LETTER);
        tap(12, 32, 32);
        check("valid_after_submit", {31'b0, cur_valid}, 32'h0);

        // Key 8 owns only 'Y','Z': taps wrap; key 9 owns nothing.
        expect_press(8, 8'h59, 1'b1, K_NONE);
        tap(8, 32, 32);
        expect_press(8, 8'h5A, 1'b1, K_NONE);
        tap(8, 32, 32);
        expect_press(8, 8'h59, 1'b1, K_NONE);
        tap(8, 32, 32);
        expect_press(9, 8'h59, 1'b1, K_NONE);
        tap(9, 32, 32);

        // Tap timeout: second tap after the window restarts at 'A'.
        expect_press(0, 8'h41, 1'b1, K_NONE);
        tap(0, 32, 32);
        repeat (150) @(negedge clk);
        expect_press(0, 8'h41, 1'b1, K_NONE);
        tap(0, 32, 32);
        expect_press(12, 8'h41, 1'b0, K_LETTER);
        tap(12, 32, 32);

        // Submit with nothing pending -> entry_error; submit word; clear with no pulse.
        expect_press(12, 8'h41, 1'b0, K_ERR);
        tap(12, 32, 32);
        expect_press(14, 8'h41, 1'b0, K_WORD);
        tap(14, 32, 32);
        expect_press(1, 8'h44, 1'b1, K_NONE);
        tap(1, 32, 32);
        expect_press(13, 8'h44, 1'b0, K_NONE);
        tap(13, 32, 32);

        // Two closures in one frame (same column, then different columns): no press.
        held[0] = 1'b1; held[4] = 1'b1;
        repeat (40) @(negedge clk);
        held = 16'h0000;
        repeat (32) @(negedge clk);
        held[0] = 1'b1; held[1] = 1'b1;
        repeat (40) @(negedge clk);
        held = 16'h0000;
        repeat (32) @(negedge clk);

        // Reset during debounce aborts the press; held key is accepted again afterwards.
        held[5] = 1'b1;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        expect_press(5, 8'h50, 1'b1, K_NONE);
        repeat (40) @(negedge clk);
        held = 16'h0000;
        repeat (32) @(negedge clk);

        check("queue_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
